// File: rtl/risc_v_exec_ctrl.sv
// -----------------------------------------------------------------------------
// risc_v_exec_ctrl
//   Run / halt / single-step sequencer for the single-cycle RISC-V core.
//   The two board switches are synchronised and debounced. Filtered SW_RUN
//   becomes a run level. A rising edge of filtered SW_STEP becomes a one-cycle
//   step pulse. A small FSM turns these into CORE_EN, which gates PC update,
//   REG_WRITE and MEM_WRITE in the core. Saturating cycle and retired counters
//   are provided for HEX/debug readout.
//
//   Optional feature macro: BREAKPOINT_EN
//     defined   : RUN stops before committing the instruction at BP_ADDR and
//                 enters BREAK.
//     undefined : BP_ADDR/BP_VALID are ignored and BREAK is unreachable.
//
// Parameters
//   DEB_CYCLES  consecutive stable samples needed to change a filtered switch (>=1)
//   CNT_WIDTH   width of CYCLE_CNT / RETIRED_CNT
//
// Ports
//   CLK          in   system clock, rising edge
//   RST          in   synchronous, active-low reset
//   SW_RUN       in   raw run switch, asynchronous to CLK
//   SW_STEP      in   raw step switch, asynchronous to CLK
//   PC           in   current core PC
//   BP_ADDR      in   breakpoint address (BREAKPOINT_EN only)
//   BP_VALID     in   breakpoint armed (BREAKPOINT_EN only)
//   CORE_EN      out  core may commit this cycle
//   STATE        out  00 HALT, 01 RUN, 10 STEP, 11 BREAK (FSM debug view)
//   HALTED       out  1 in HALT or BREAK
//   CYCLE_CNT    out  cycles since reset release, saturating
//   RETIRED_CNT  out  cycles with CORE_EN=1, saturating
//
// Control semantics: there is no valid/ready handshake. CORE_EN is a
// same-cycle qualifier. The core commits on any rising edge where CORE_EN=1,
// and every such edge is counted once in RETIRED_CNT.
// -----------------------------------------------------------------------------
module risc_v_exec_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SW_RUN,
  input  logic                 SW_STEP,
  input  logic [31:0]          PC,
  input  logic [31:0]          BP_ADDR,
  input  logic                 BP_VALID,
  output logic                 CORE_EN,
  output logic [1:0]           STATE,
  output logic                 HALTED,
  output logic [CNT_WIDTH-1:0] CYCLE_CNT,
  output logic [CNT_WIDTH-1:0] RETIRED_CNT
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Index 0 = run switch, index 1 = step switch
  logic [1:0]    w_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_filt;
  logic [DW-1:0] r_deb_cnt [2];
  logic          r_step_q;

  logic          w_run_lvl;
  logic          w_step_pulse;
  logic          w_bp_hit;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_core_en;

  logic [CNT_WIDTH-1:0] r_cycle_cnt;
  logic [CNT_WIDTH-1:0] r_retired_cnt;

  assign w_raw = {SW_STEP, SW_RUN};

  // Two-flop synchroniser followed by a stability filter. The counter tracks
  // how many consecutive synced samples disagree with the filtered value.
  // One agreeing sample restarts it. For a 1-bit signal, "consecutive equal
  // samples" and "consecutive samples that differ from the output" mean the
  // same thing.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_filt   <= '0;
      r_step_q <= 1'b0;
      for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_step_q <= r_filt[1];
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_MAX) begin
          r_filt[i]    <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_run_lvl    = r_filt[0];
  assign w_step_pulse = r_filt[1] & ~r_step_q;

`ifdef BREAKPOINT_EN
  assign w_bp_hit = BP_VALID && (PC == BP_ADDR);
`else
  assign w_bp_hit = 1'b0;
  logic w_bp_unused;
  assign w_bp_unused = ^{PC, BP_ADDR, BP_VALID};
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_HALT;
    else      r_state <= w_state_nxt;
  end

  // Next state and CORE_EN decode
  always_comb begin
    w_state_nxt = S_HALT;
    w_core_en   = 1'b0;
    case (r_state)
      S_HALT: begin
        // RUN has priority, so a simultaneous step pulse is dropped.
        if (w_run_lvl)         w_state_nxt = S_RUN;
        else if (w_step_pulse) w_state_nxt = S_STEP;
        else                   w_state_nxt = S_HALT;
      end
      S_RUN: begin
        // A breakpoint hit blocks the commit of the matching instruction.
        w_core_en = ~w_bp_hit;
        if (!w_run_lvl)    w_state_nxt = S_HALT;
        else if (w_bp_hit) w_state_nxt = S_BREAK;
        else               w_state_nxt = S_RUN;
      end
      S_STEP: begin
        // Exactly one commit. The breakpoint compare is not applied here, so
        // a step out of BREAK executes the breakpoint instruction.
        w_core_en   = 1'b1;
        w_state_nxt = S_HALT;
      end
`ifdef BREAKPOINT_EN
      S_BREAK: begin
        if (!w_run_lvl)        w_state_nxt = S_HALT;
        else if (w_step_pulse) w_state_nxt = S_STEP;
        else                   w_state_nxt = S_BREAK;
      end
`endif
      default: w_state_nxt = S_HALT;
    endcase
  end

  // Saturating counters
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
    end else begin
      if (r_cycle_cnt != CNT_MAX) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_core_en && (r_retired_cnt != CNT_MAX))
        r_retired_cnt <= r_retired_cnt + 1'b1;
    end
  end

  assign CORE_EN     = w_core_en;
  assign STATE       = r_state;
  assign HALTED      = (r_state == S_HALT) || (r_state == S_BREAK);
  assign CYCLE_CNT   = r_cycle_cnt;
  assign RETIRED_CNT = r_retired_cnt;

endmodule

// File: tb/tb_risc_v_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_risc_v_exec_ctrl
//   Directed bench for risc_v_exec_ctrl using DEB_CYCLES=4. A second instance
//   with CNT_WIDTH=4 shares all inputs so that counter saturation can be seen.
//   Breakpoint steps are included only when BREAKPOINT_EN is defined.
// -----------------------------------------------------------------------------
module tb_risc_v_exec_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SW_RUN;
  logic        SW_STEP;
  logic [31:0] PC;
  logic [31:0] BP_ADDR;
  logic        BP_VALID;

  logic        core_en;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] retired_cnt;

  logic        core_en4;
  logic [1:0]  state4;
  logic        halted4;
  logic [3:0]  cycle_cnt4;
  logic [3:0]  retired_cnt4;

  int total = 0;
  int bad   = 0;
  int n_en;
  int n_bad_state;

  // Clock and reset
  always #5 CLK = ~CLK;

  risc_v_exec_ctrl #(.DEB_CYCLES(4), .CNT_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .SW_RUN(SW_RUN), .SW_STEP(SW_STEP),
    .PC(PC), .BP_ADDR(BP_ADDR), .BP_VALID(BP_VALID),
    .CORE_EN(core_en), .STATE(state), .HALTED(halted),
    .CYCLE_CNT(cycle_cnt), .RETIRED_CNT(retired_cnt)
  );

  risc_v_exec_ctrl #(.DEB_CYCLES(4), .CNT_WIDTH(4)) dut4 (
    .CLK(CLK), .RST(RST), .SW_RUN(SW_RUN), .SW_STEP(SW_STEP),
    .PC(PC), .BP_ADDR(BP_ADDR), .BP_VALID(BP_VALID),
    .CORE_EN(core_en4), .STATE(state4), .HALTED(halted4),
    .CYCLE_CNT(cycle_cnt4), .RETIRED_CNT(retired_cnt4)
  );

  // Advance one rising edge, then settle away from it
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b0; SW_RUN = 1'b0; SW_STEP = 1'b0;
    PC = 32'h0; BP_ADDR = 32'h0; BP_VALID = 1'b0;

    // Reset held for three cycles
    tick(3);
    chk("rst_state",   {30'd0, state},   32'd0);
    chk("rst_core_en", {31'd0, core_en}, 32'd0);
    chk("rst_halted",  {31'd0, halted},  32'd1);
    chk("rst_cycle",   cycle_cnt,        32'd0);
    chk("rst_retired", retired_cnt,      32'd0);

    // Run switch: HALT->RUN on the 7th edge after the change
    RST = 1'b1; SW_RUN = 1'b1;
    tick(6);
    chk("run_lat_before", {30'd0, state}, 32'd0);
    tick();
    chk("run_state",   {30'd0, state},   32'd1);
    chk("run_core_en", {31'd0, core_en}, 32'd1);
    chk("run_halted",  {31'd0, halted},  32'd0);
    chk("run_cycle",   cycle_cnt,        32'd7);
    chk("run_retired0", retired_cnt,     32'd0);
    tick(5);
    chk("run_retired5", retired_cnt,     32'd5);
    SW_RUN = 1'b0;
    tick(6);
    chk("halt_lat_before", {30'd0, state}, 32'd1);
    tick();
    chk("halt_state",   {30'd0, state}, 32'd0);
    chk("halt_retired", retired_cnt,    32'd12);
    chk("halt_cycle",   cycle_cnt,      32'd19);
    // 4-bit build: cycles stuck at F, retired count is 12
    chk("sat_cycle4",   {28'd0, cycle_cnt4},   32'hF);
    chk("sat_retired4", {28'd0, retired_cnt4}, 32'hC);

    // Step glitch of 3 cycles must not step
    SW_STEP = 1'b1;
    tick(3);
    SW_STEP = 1'b0;
    n_bad_state = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (state !== 2'b00 || core_en !== 1'b0) n_bad_state++;
    end
    chk("glitch_no_step", n_bad_state, 32'd0);
    chk("glitch_retired", retired_cnt, 32'd12);

    // Step held 10 cycles: exactly one commit
    SW_STEP = 1'b1;
    n_en = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (core_en === 1'b1) n_en++;
      if (i == 7) begin
        chk("step_state",   {30'd0, state},   32'd2);
        chk("step_core_en", {31'd0, core_en}, 32'd1);
      end
      if (i == 8) begin
        chk("step_back_halt", {30'd0, state}, 32'd0);
        chk("step_retired",   retired_cnt,    32'd13);
      end
      if (i == 10) SW_STEP = 1'b0;
    end
    chk("step_one_commit", n_en, 32'd1);
    chk("step_cycle4_sticky", {28'd0, cycle_cnt4}, 32'hF);

    // Run and step together: RUN wins, the pulse is dropped
    SW_RUN = 1'b1; SW_STEP = 1'b1;
    tick(7);
    chk("both_run", {30'd0, state}, 32'd1);
    tick();
    chk("both_still_run", {30'd0, state}, 32'd1);
    SW_RUN = 1'b0;
    tick(7);
    chk("both_halt", {30'd0, state}, 32'd0);
    tick();
    chk("both_no_late_step", {30'd0, state}, 32'd0);
    chk("both_retired", retired_cnt, 32'd21);
    SW_STEP = 1'b0;
    tick(8);

    // Reset during a STEP cycle
    SW_STEP = 1'b1;
    tick(7);
    chk("rst_step_in_step", {30'd0, state}, 32'd2);
    RST = 1'b0;
    tick();
    chk("rst_step_state",   {30'd0, state},   32'd0);
    chk("rst_step_core_en", {31'd0, core_en}, 32'd0);
    chk("rst_step_retired", retired_cnt,      32'd0);
    chk("rst_step_cycle",   cycle_cnt,        32'd0);
    RST = 1'b1; SW_STEP = 1'b0;
    tick(3);
    chk("post_rst_cycle", cycle_cnt,       32'd3);
    chk("post_rst_state", {30'd0, state},  32'd0);

`ifdef BREAKPOINT_EN
    // Breakpoint at 0x10 while running through 0,4,8,C,10
    BP_VALID = 1'b1; BP_ADDR = 32'h10; PC = 32'h0; SW_RUN = 1'b1;
    tick(7);
    chk("bp_run", {30'd0, state}, 32'd1);
    tick(); PC = 32'h4;
    tick(); PC = 32'h8;
    tick(); PC = 32'hC;
    tick(); PC = 32'h10;
    #1;
    chk("bp_hit_core_en", {31'd0, core_en}, 32'd0);
    chk("bp_retired_pre", retired_cnt,      32'd4);
    tick();
    chk("bp_break_state",  {30'd0, state},  32'd3);
    chk("bp_break_halted", {31'd0, halted}, 32'd1);
    SW_STEP = 1'b1;
    tick(6);
    chk("bp_break_hold", {30'd0, state}, 32'd3);
    tick();
    chk("bp_step_state",   {30'd0, state},   32'd2);
    chk("bp_step_core_en", {31'd0, core_en}, 32'd1);
    tick();
    chk("bp_step_halt",    {30'd0, state}, 32'd0);
    chk("bp_step_retired", retired_cnt,    32'd5);
    PC = 32'h14;
    tick();
    chk("bp_resume_run", {30'd0, state}, 32'd1);
    SW_RUN = 1'b0; SW_STEP = 1'b0;
    tick(10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
